// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle CPU control FSM: FETCH -> GETREGS -> EXEC -> [MEM] -> WB, plus HALTED.
// Define INTERRUPT_EN to add the int_req/int_ack handshake and the INT state after WB.
module cpu_cycle_sequencer #(
    parameter logic [3:0] OP_READ  = 4'b1110,
    parameter logic [3:0] OP_WRITE = 4'b1101,
    parameter logic [3:0] OP_HALT  = 4'b1111,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef INTERRUPT_EN
    input  logic             int_req,
    output logic             int_ack,
`endif
    input  logic [3:0]       instrOP,
    input  logic             bus_done,
    input  logic             stall,
    output logic             fetch,
    output logic             getRegs,
    output logic             bus_req,
    output logic             bus_we,
    output logic             alu_en,
    output logic             reg_we,
    output logic             pc_we,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_GETREGS,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
`ifdef INTERRUPT_EN
        , ST_INT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_INIT:    state_d = ST_FETCH;
            ST_FETCH:   if (bus_done) state_d = ST_GETREGS;
            ST_GETREGS: state_d = ST_EXEC;
            ST_EXEC: begin
                if (!stall) begin
                    if (instrOP == OP_HALT)
                        state_d = ST_HALTED;
                    else if (instrOP == OP_READ || instrOP == OP_WRITE)
                        state_d = ST_MEM;
                    else
                        state_d = ST_WB;
                end
            end
            ST_MEM:     if (bus_done) state_d = ST_WB;
            ST_WB: begin
                count_d = count_q + CNT_W'(1);
`ifdef INTERRUPT_EN
                state_d = int_req ? ST_INT : ST_FETCH;
`else
                state_d = ST_FETCH;
`endif
            end
            ST_HALTED:  state_d = ST_HALTED;
`ifdef INTERRUPT_EN
            ST_INT:     state_d = ST_FETCH;
`endif
            default:    state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            // Written only on change so the count holds between retirements.
            if (state_q == ST_WB) count_q <= count_d;
        end
    end

    // Outputs decode the registered state, so reset clears them in the same timestep.
    assign fetch       = (state_q == ST_FETCH);
    assign getRegs     = (state_q == ST_GETREGS);
    assign bus_req     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign bus_we      = (state_q == ST_MEM) && (instrOP == OP_WRITE);
    assign alu_en      = (state_q == ST_EXEC);
    assign reg_we      = (state_q == ST_WB) && (instrOP != OP_WRITE);
    assign pc_we       = (state_q == ST_WB);
    assign halted      = (state_q == ST_HALTED);
    assign instr_count = count_q;
`ifdef INTERRUPT_EN
    assign int_ack     = (state_q == ST_INT);
`endif

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: per-instruction expected cycle traces
// built from phase lengths, table vectors, random instructions and reset/wrap corners.
module tb_cpu_cycle_sequencer;

    localparam logic [3:0] OP_READ  = 4'b1110;
    localparam logic [3:0] OP_WRITE = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  instrOP;
    logic        bus_done, stall;
    logic        fetch, getRegs, bus_req, bus_we, alu_en, reg_we, pc_we, halted;
    logic [31:0] instr_count;
`ifdef INTERRUPT_EN
    logic        int_req, int_ack;
`endif

    cpu_cycle_sequencer #(.OP_READ(OP_READ), .OP_WRITE(OP_WRITE), .OP_HALT(OP_HALT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
`ifdef INTERRUPT_EN
        .int_req(int_req), .int_ack(int_ack),
`endif
        .instrOP(instrOP), .bus_done(bus_done), .stall(stall),
        .fetch(fetch), .getRegs(getRegs), .bus_req(bus_req), .bus_we(bus_we),
        .alu_en(alu_en), .reg_we(reg_we), .pc_we(pc_we), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt;

    // {fetch, getRegs, bus_req, bus_we, alu_en, reg_we, pc_we, halted}
    function automatic logic [7:0] outv();
        return {fetch, getRegs, bus_req, bus_we, alu_en, reg_we, pc_we, halted};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noise();
        bus_done = 1'($urandom);
        stall    = 1'($urandom);
`ifdef INTERRUPT_EN
        int_req  = 1'($urandom);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0; bus_done = 1'b0; stall = 1'b0;
        #1 chk("init_outputs", {24'd0, outv()}, 32'd0);
    endtask

    // One instruction: wf fetch cycles, st stall cycles, wm mem cycles (memory ops only).
    // abort_at >= 0 asserts reset in that MEM cycle; irq requests an interrupt in WB.
    task automatic run_instr(input logic [3:0] op, input int wf, input int st, input int wm,
                             input logic erwe, input logic ebwe, input int abort_at, input bit irq);
        bit ismem;
        ismem = (op == OP_READ) || (op == OP_WRITE);
        for (int i = 0; i < wf; i++) begin
            @(negedge clk);
            noise(); instrOP = 4'($urandom); bus_done = (i == wf - 1);
            #1 chk("fetch_phase", {24'd0, outv()}, 32'h000000A0);
            if (i == 0) chk("count_at_fetch", instr_count, model_cnt);
        end
        @(negedge clk);
        noise(); instrOP = op;
        #1 chk("getregs_phase", {24'd0, outv()}, 32'h00000040);
        for (int i = 0; i <= st; i++) begin
            @(negedge clk);
            noise(); stall = (i < st);
            #1 chk("exec_phase", {24'd0, outv()}, 32'h00000008);
        end
        if (op == OP_HALT) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                noise(); instrOP = 4'($urandom);
                #1 chk("halted_phase", {24'd0, outv()}, 32'h00000001);
            end
            return;
        end
        if (ismem) begin
            for (int i = 0; i < wm; i++) begin
                @(negedge clk);
                noise(); bus_done = (i == wm - 1) && (i != abort_at);
                #1 chk("mem_phase", {24'd0, outv()}, {24'd0, 2'b00, 1'b1, ebwe, 4'b0000});
                if (i == abort_at) begin
                    #1 reset = 1'b1;
                    #1 chk("reset_mid_mem_outputs", {24'd0, outv()}, 32'd0);
                    chk("reset_mid_mem_count", instr_count, 32'd0);
                    model_cnt = '0;
                    return;
                end
            end
        end
        @(negedge clk);
        noise();
`ifdef INTERRUPT_EN
        int_req = irq;
`endif
        #1 chk("wb_phase", {24'd0, outv()}, {24'd0, 5'b00000, erwe, 2'b10});
        model_cnt = model_cnt + 32'd1;
`ifdef INTERRUPT_EN
        if (irq) begin
            @(negedge clk);
            noise();
            #1 chk("int_ack", {31'd0, int_ack}, 32'd1);
            chk("int_outputs", {24'd0, outv()}, 32'd0);
        end
`else
        if (irq) chk("irq_unsupported_build", 32'd0, 32'd1);
`endif
    endtask

    typedef struct {
        logic [3:0] op;
        int         wf, st, wm;
        logic       erwe, ebwe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'b0000,  3, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{OP_WRITE, 1, 0, 2, 1'b0, 1'b1};
        vecs[2] = '{OP_READ,  1, 3, 1, 1'b1, 1'b0};
        vecs[3] = '{4'b0101,  1, 1, 0, 1'b1, 1'b0};
        vecs[4] = '{OP_WRITE, 2, 2, 1, 1'b0, 1'b1};
        vecs[5] = '{OP_READ,  1, 0, 3, 1'b1, 1'b0};

        reset = 1'b1; bus_done = 1'b0; stall = 1'b0; instrOP = 4'd0;
`ifdef INTERRUPT_EN
        int_req = 1'b0;
`endif
        model_cnt = '0;
        #1 chk("reset_outputs", {24'd0, outv()}, 32'd0);
        chk("reset_count", instr_count, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        foreach (vecs[k])
            run_instr(vecs[k].op, vecs[k].wf, vecs[k].st, vecs[k].wm,
                      vecs[k].erwe, vecs[k].ebwe, -1, 1'b0);

        // Halt, then only reset recovers.
        run_instr(OP_HALT, 2, 1, 0, 1'b0, 1'b0, -1, 1'b0);
        #1 reset = 1'b1;
        #1 chk("halt_reset_outputs", {24'd0, outv()}, 32'd0);
        chk("halt_reset_count", instr_count, 32'd0);
        model_cnt = '0;
        release_reset();
        run_instr(4'b0010, 1, 0, 0, 1'b1, 1'b0, -1, 1'b0);

        // Reset in the middle of a pending memory transaction.
        run_instr(OP_READ, 1, 0, 4, 1'b1, 1'b0, 2, 1'b0);
        release_reset();
        run_instr(4'b0001, 1, 0, 0, 1'b1, 1'b0, -1, 1'b0);

        // Counter wrap from all-ones.
        @(posedge clk);
        #1 force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        model_cnt = 32'hFFFF_FFFF;
        run_instr(4'b0011, 1, 0, 0, 1'b1, 1'b0, -1, 1'b0);
        run_instr(OP_WRITE, 1, 0, 1, 1'b0, 1'b1, -1, 1'b0);

`ifdef INTERRUPT_EN
        run_instr(4'b0100, 1, 0, 0, 1'b1, 1'b0, -1, 1'b1);
`endif

        for (int n = 0; n < 30; n++) begin
            logic [3:0] op;
            int         r;
            r  = int'($urandom_range(0, 3));
            op = (r == 0) ? OP_READ : (r == 1) ? OP_WRITE : 4'($urandom_range(0, 12));
            run_instr(op, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(1, 3)), op != OP_WRITE, op == OP_WRITE, -1, 1'b0);
        end

        @(negedge clk);
        bus_done = 1'b0; stall = 1'b0;
        #1 chk("count_final", instr_count, model_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
